// File: rtl/bfly_sched.sv
// bfly_sched: frame-level scheduler for the radix-2 butterfly add/subtract stage.
// Sequences din1/din2 bank loads from the upstream stream, presents each
// butterfly result downstream, and walks pair/stage indices across a frame.
// Optional stall counter: define BFLY_SCHED_STALL_CNT_EN to add stall_cnt.
module bfly_sched #(
   parameter int NUM_PAIRS  = 16,
   parameter int NUM_STAGES = 9,
   parameter int PW         = $clog2(NUM_PAIRS),
   parameter int SW         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          ld1_en,
   output logic          ld2_en,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] pair_idx,
   output logic [SW-1:0] stage_idx,
   output logic          busy,
   output logic          frame_done
`ifdef BFLY_SCHED_STALL_CNT_EN
   ,
   output logic [15:0]   stall_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, LOAD1, LOAD2, EXEC} state_t;

   localparam logic [PW-1:0] LAST_PAIR  = PW'(NUM_PAIRS - 1);
   localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

   state_t r_state;
   state_t w_state_nxt;
   logic   w_start_acc;
   logic   w_abort_acc;
   logic   w_adv;
   logic   w_done;
   logic   w_last_pair;
   logic   w_last_stage;

   assign w_last_pair  = (pair_idx == LAST_PAIR);
   assign w_last_stage = (stage_idx == LAST_STAGE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state and handshake decode; abort overrides any same-cycle advance
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      ld1_en      = 1'b0;
      ld2_en      = 1'b0;
      out_valid   = 1'b0;
      busy        = (r_state != IDLE);
      w_start_acc = 1'b0;
      w_abort_acc = 1'b0;
      w_adv       = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_start_acc = 1'b1;
               w_state_nxt = LOAD1;
            end
         end
         LOAD1: begin
            in_ready = 1'b1;
            ld1_en   = in_valid;
            if (in_valid) w_state_nxt = LOAD2;
         end
         LOAD2: begin
            in_ready = 1'b1;
            ld2_en   = in_valid;
            if (in_valid) w_state_nxt = EXEC;
         end
         EXEC: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_adv = 1'b1;
               if (w_last_pair && w_last_stage) begin
                  w_done      = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = LOAD1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (abort && (r_state != IDLE)) begin
         w_abort_acc = 1'b1;
         w_adv       = 1'b0;
         w_done      = 1'b0;
         w_state_nxt = IDLE;
      end
   end

   // Pair/stage indices and the completion pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pair_idx   <= '0;
         stage_idx  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= w_done;
         if (w_start_acc || w_abort_acc) begin
            pair_idx  <= '0;
            stage_idx <= '0;
         end else if (w_adv) begin
            if (w_last_pair) begin
               pair_idx <= '0;
               if (w_last_stage) stage_idx <= '0;
               else              stage_idx <= stage_idx + 1'b1;
            end else begin
               pair_idx <= pair_idx + 1'b1;
            end
         end
      end
   end

`ifdef BFLY_SCHED_STALL_CNT_EN
   logic w_stall;

   // A stall is any cycle waiting on upstream data or downstream acceptance
   always_comb begin
      w_stall = (((r_state == LOAD1) || (r_state == LOAD2)) && !in_valid) ||
                ((r_state == EXEC) && !out_ready);
   end

   // Saturating stall counter, cleared when a frame starts
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                      stall_cnt <= '0;
      else if (w_start_acc)                         stall_cnt <= '0;
      else if (w_stall && (stall_cnt != 16'hFFFF))  stall_cnt <= stall_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_bfly_sched.sv
// tb_bfly_sched: vector table, directed corner sequences and randomized
// traffic against a behavioural frame model for bfly_sched.
module tb_bfly_sched;

   localparam int NP   = 16;
   localparam int NS   = 9;
   localparam int PW   = 4;
   localparam int SW   = 4;
   localparam int NTOT = NP * NS;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic          in_ready, ld1_en, ld2_en, out_valid, busy, frame_done;
   logic [PW-1:0] pair_idx;
   logic [SW-1:0] stage_idx;
`ifdef BFLY_SCHED_STALL_CNT_EN
   logic [15:0]   stall_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: phase 0 idle, 1 wants operand 1, 2 wants operand 2,
   // 3 result pending; m_n is the flat butterfly number within the frame.
   int   m_phase;
   int   m_n;
   int   m_stall;
   logic m_fd;

   bfly_sched #(
      .NUM_PAIRS (NP),
      .NUM_STAGES(NS),
      .PW        (PW),
      .SW        (SW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ld1_en    (ld1_en),
      .ld2_en    (ld2_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pair_idx  (pair_idx),
      .stage_idx (stage_idx),
      .busy      (busy),
      .frame_done(frame_done)
`ifdef BFLY_SCHED_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [3:0]  in;     // {start, abort, in_valid, out_ready}
      logic [4:0]  ctl;    // {in_ready, ld1_en, ld2_en, out_valid, busy}
      logic [3:0]  p;
      logic [3:0]  s;
      logic        fd;
      logic [15:0] stall;
   } vec_t;

   vec_t tbl [15];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] dut_vec();
      return {18'b0, in_ready, ld1_en, ld2_en, out_valid, busy, frame_done, stage_idx, pair_idx};
   endfunction

   function automatic logic [31:0] mdl_vec(input logic iv);
      logic ir, l1, l2, ov, bz;
      ir = (m_phase == 1) || (m_phase == 2);
      l1 = (m_phase == 1) && iv;
      l2 = (m_phase == 2) && iv;
      ov = (m_phase == 3);
      bz = (m_phase != 0);
      return {18'b0, ir, l1, l2, ov, bz, m_fd, SW'(m_n / NP), PW'(m_n % NP)};
   endfunction

   task automatic mdl_reset();
      m_phase = 0;
      m_n     = 0;
      m_stall = 0;
      m_fd    = 1'b0;
   endtask

   task automatic mdl_clock(input logic st, input logic ab, input logic iv, input logic rdy);
      logic stalled;
      stalled = ((m_phase == 1 || m_phase == 2) && !iv) || (m_phase == 3 && !rdy);
      m_fd = 1'b0;
      if (m_phase == 0) begin
         if (st) begin
            m_phase = 1;
            m_n     = 0;
            m_stall = 0;
         end
      end else begin
         if (stalled && m_stall < 65535) m_stall++;
         if (ab) begin
            m_phase = 0;
            m_n     = 0;
         end else if (m_phase == 1) begin
            if (iv) m_phase = 2;
         end else if (m_phase == 2) begin
            if (iv) m_phase = 3;
         end else if (rdy) begin
            if (m_n == NTOT - 1) begin
               m_phase = 0;
               m_n     = 0;
               m_fd    = 1'b1;
            end else begin
               m_n++;
               m_phase = 1;
            end
         end
      end
   endtask

   // One clock cycle: drive, compare against the model, clock, advance model.
   task automatic step(input logic st, input logic ab, input logic iv, input logic rdy,
                       input bit chk, input string name);
      start = st; abort = ab; in_valid = iv; out_ready = rdy;
      #1;
      if (chk) begin
         check(name, dut_vec(), mdl_vec(iv));
`ifdef BFLY_SCHED_STALL_CNT_EN
         check({name, "_stall"}, 32'(stall_cnt), 32'(m_stall));
`endif
      end
      @(posedge clk);
      mdl_clock(st, ab, iv, rdy);
      #1;
   endtask

   task automatic run_frame(input string tag);
      int fd_cycle = -1;
      int fd_count = 0;
      int execs    = 0;
      check({tag, "_fd_c0"}, 32'(frame_done), 32'd0);
      for (int c = 0; c < 440; c++) begin
         step(c == 0, 1'b0, 1'b1, 1'b1, 1'b1, tag);
         if (frame_done) begin
            fd_count++;
            if (fd_cycle < 0) fd_cycle = c + 1;
         end
         if (out_valid) execs++;
      end
      check({tag, "_fd_cycle"}, 32'(fd_cycle), 32'd433);
      check({tag, "_fd_count"}, 32'(fd_count), 32'd1);
      check({tag, "_execs"}, 32'(execs), 32'd144);
      check({tag, "_end_idx"}, {24'b0, stage_idx, pair_idx}, 32'd0);
      check({tag, "_end_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      bit found;
      tbl[0]  = '{4'b1000, 5'b00000, 4'd0, 4'd0, 1'b0, 16'd0};
      tbl[1]  = '{4'b0000, 5'b10001, 4'd0, 4'd0, 1'b0, 16'd0};
      tbl[2]  = '{4'b0000, 5'b10001, 4'd0, 4'd0, 1'b0, 16'd1};
      tbl[3]  = '{4'b0010, 5'b11001, 4'd0, 4'd0, 1'b0, 16'd2};
      tbl[4]  = '{4'b0000, 5'b10001, 4'd0, 4'd0, 1'b0, 16'd2};
      tbl[5]  = '{4'b1010, 5'b10101, 4'd0, 4'd0, 1'b0, 16'd3};
      tbl[6]  = '{4'b0010, 5'b00011, 4'd0, 4'd0, 1'b0, 16'd3};
      tbl[7]  = '{4'b0011, 5'b00011, 4'd0, 4'd0, 1'b0, 16'd4};
      tbl[8]  = '{4'b0011, 5'b11001, 4'd1, 4'd0, 1'b0, 16'd4};
      tbl[9]  = '{4'b0111, 5'b10101, 4'd1, 4'd0, 1'b0, 16'd4};
      tbl[10] = '{4'b0011, 5'b00000, 4'd0, 4'd0, 1'b0, 16'd4};
      tbl[11] = '{4'b1111, 5'b00000, 4'd0, 4'd0, 1'b0, 16'd4};
      tbl[12] = '{4'b0011, 5'b11001, 4'd0, 4'd0, 1'b0, 16'd0};
      tbl[13] = '{4'b0101, 5'b10001, 4'd0, 4'd0, 1'b0, 16'd0};
      tbl[14] = '{4'b0000, 5'b00000, 4'd0, 4'd0, 1'b0, 16'd1};

      mdl_reset();
      #1 rst = 1'b1;
      #11;
      check("reset", dut_vec(), 32'd0);
`ifdef BFLY_SCHED_STALL_CNT_EN
      check("reset_stall", 32'(stall_cnt), 32'd0);
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Vector table: gaps, start while busy, abort priority, start beats abort
      for (int i = 0; i < 15; i++) begin
         {start, abort, in_valid, out_ready} = tbl[i].in;
         #1;
         check($sformatf("tbl%0d", i), dut_vec(),
               {18'b0, tbl[i].ctl, tbl[i].fd, tbl[i].s, tbl[i].p});
`ifdef BFLY_SCHED_STALL_CNT_EN
         check($sformatf("tbl%0d_stall", i), 32'(stall_cnt), 32'(tbl[i].stall));
`endif
         @(posedge clk);
         mdl_clock(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
         #1;
      end

      // Full-throughput frame
      run_frame("frame1");

      // Backpressure on pair 3 of stage 0
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "bp_run");
      found = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (out_valid && pair_idx == 4'd3 && stage_idx == 4'd0) begin
            found = 1'b1;
            break;
         end
         step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "bp_run");
      end
      check("bp_reach", 32'(found), 32'd1);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "bp_hold");
         check("bp_ov_held", 32'(out_valid), 32'd1);
         check("bp_pair_held", 32'(pair_idx), 32'd3);
      end
`ifdef BFLY_SCHED_STALL_CNT_EN
      check("bp_stall5", 32'(stall_cnt), 32'd5);
`endif
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "bp_release");
      check("bp_adv", {24'b0, stage_idx, pair_idx}, 32'h04);
      check("bp_load1", {28'b0, in_ready, ld1_en, ld2_en, out_valid}, 32'b1100);

      // Stage wrap after pair 15 of stage 0
      found = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (out_valid && pair_idx == 4'd15 && stage_idx == 4'd0) begin
            found = 1'b1;
            break;
         end
         step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "wrap_run");
      end
      check("wrap_reach", 32'(found), 32'd1);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "wrap_exec");
      check("wrap_idx", {24'b0, stage_idx, pair_idx}, 32'h10);
      check("wrap_load1", {28'b0, in_ready, ld1_en, ld2_en, out_valid}, 32'b1100);

      // Start while busy is ignored; abort beats an EXEC handshake
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "ab_l1");
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "ab_start_busy");
      check("ab_exec_kept", {23'b0, out_valid, stage_idx, pair_idx}, 32'h110);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "ab_abort");
      check("ab_idle", {23'b0, busy, stage_idx, pair_idx}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ab_after");
      check("ab_no_fd", 32'(frame_done), 32'd0);

      // Asynchronous reset in stage 4, then a clean frame
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "rst_run");
      found = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (stage_idx == 4'd4) begin
            found = 1'b1;
            break;
         end
         step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "rst_run");
      end
      check("rst_reach", 32'(found), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("rst_async", dut_vec(), 32'd0);
`ifdef BFLY_SCHED_STALL_CNT_EN
      check("rst_async_stall", 32'(stall_cnt), 32'd0);
`endif
      mdl_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      run_frame("frame2");

      // Randomized traffic against the model
      for (int k = 0; k < 4000; k++) begin
         step($urandom_range(0, 7) == 0, $urandom_range(0, 511) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b1, "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bfly_sched.md
# bfly_sched

Frame-level scheduler for the 16-lane radix-2 butterfly add/subtract stage of the FFT datapath. It sequences the loading of the two operand vector banks (din1, din2) from an upstream valid/ready stream, and presents each butterfly result downstream under a valid/ready handshake. It tracks pair and stage indices across a full FFT frame and signals frame completion. It drives control only; operand banks and the combinational butterfly live in the datapath.

## Interface
- NUM_PAIRS, 16: butterfly vector pairs per stage (≥2)
- NUM_STAGES, 9: FFT stages per frame (≥1)
- PW, $clog2(NUM_PAIRS): pair_idx width
- SW, $clog2(NUM_STAGES): stage_idx width

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin frame; sampled only in IDLE
- abort  in  1  synchronous abandon of current frame
- in_valid  in  1  upstream operand vector available
- in_ready  out  1  scheduler accepts operand vector
- ld1_en  out  1  capture enable for din1 bank
- ld2_en  out  1  capture enable for din2 bank
- out_valid  out  1  butterfly result valid downstream
- out_ready  in  1  downstream accepts result
- pair_idx  out  PW  current pair within stage
- stage_idx  out  SW  current stage
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle completion pulse
- stall_cnt  out  16  stall counter (only with macro, see Configuration)

## Operation
- FSM states: IDLE, LOAD1, LOAD2, EXEC.
- IDLE: start=1 → LOAD1; pair_idx, stage_idx cleared to 0.
- LOAD1: in_ready=1; ld1_en = in_valid; on handshake → LOAD2.
- LOAD2: in_ready=1; ld2_en = in_valid; on handshake → EXEC.
- EXEC: out_valid=1; on out_ready, advance:
  - pair_idx < NUM_PAIRS-1: pair_idx+1 → LOAD1.
  - last pair, stage_idx < NUM_STAGES-1: pair_idx=0, stage_idx+1 → LOAD1.
  - last pair, last stage: → IDLE; frame_done=1 next cycle; indices reset to 0.
- out_valid held while out_ready=0; pair/stage indices stable.
- start while busy: ignored.
- abort=1 in any non-IDLE state: → IDLE next cycle, indices 0, no frame_done. abort has priority over any same-cycle handshake (handshake's ld*_en still asserts combinationally, but the state does not advance). abort and start in IDLE in the same cycle: start wins.

## Timing
- in_ready, out_valid, busy: decoded from registered state. ld1_en/ld2_en are combinational state AND in_valid.
- pair_idx, stage_idx, frame_done: registered.
- Reset values: state IDLE, all outputs 0, stall_cnt 0.
- Reset asserted mid-frame: immediate return to IDLE, no frame_done.
- Latency: start sampled in cycle 0 → LOAD1 in cycle 1.
- Throughput with no stalls: 3 cycles per pair.
- Default frame (16×9 pairs): last EXEC in cycle 432; frame_done high in cycle 433 only.
- The datapath must hold the din1/din2 banks from the capture edge through the EXEC handshake. The butterfly is combinational, so the result is valid throughout EXEC.

## Configuration
- BFLY_SCHED_STALL_CNT_EN defined: stall_cnt port and counter present.
  - Increments on each cycle in LOAD1/LOAD2 with in_valid=0, or in EXEC with out_ready=0.
  - Cleared when start is accepted.
  - Saturates at 16'hFFFF.
  - Holds its value in IDLE.
- Macro undefined: port and counter absent. All other behaviour is identical.

## Test plan
- Full throughput, defaults: in_valid=out_ready=1, start at cycle 0 → 144 EXEC cycles; frame_done only in cycle 433; final indices 0.
- Backpressure: out_ready=0 for 5 cycles in the EXEC of pair 3, stage 0 → out_valid held, pair_idx=3 stable; advance on release; stall_cnt=5 with macro.
- Input gaps: in_valid low 2 cycles in LOAD1 and 1 cycle in LOAD2 → ld1_en/ld2_en pulse once each, only on the handshakes; stall_cnt=3.
- Stage wrap: complete pair 15 of stage 0 → next cycle pair_idx=0, stage_idx=1, state LOAD1.
- Abort and start-while-busy: start pulsed in LOAD2 → ignored. abort in EXEC with out_ready=1 → IDLE, indices 0, no frame_done.
- Reset mid-frame: rst at stage 4 → all outputs 0 asynchronously. A new start afterwards completes a full frame in 433 cycles.
